// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Shared configuration macros, types and helpers for the register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef REGFILE_CONFIG_DEFINED
`define REGFILE_CONFIG_DEFINED
`define RegBus      31:0
`define RegAddrBus  4:0
`define RegNum      32
`define True        1'b1
`define False       1'b0
`endif

package regfile_pkg;

  typedef logic [`RegBus]     word_t;
  typedef logic [`RegAddrBus] addr_t;

  localparam int    REG_NUM   = `RegNum;
  localparam word_t ZERO_WORD = '0;

  // x0 is never a real target, so an access only "counts" when enabled and nonzero.
  function automatic logic addr_live(input logic en, input addr_t addr);
    return en && (addr != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Per-register busy bits tracking outstanding writebacks; bypass via REGFILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  input  logic  issue_en_i,
  input  addr_t issue_addr_i,
  input  logic  retire_en_i,
  input  addr_t retire_addr_i,
  input  logic  flush_i,
  input  logic  query_req1_i,
  input  addr_t query_addr1_i,
  input  logic  query_req2_i,
  input  addr_t query_addr2_i,
  output logic  busy1_o,
  output logic  busy2_o
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic               bypass1;
  logic               bypass2;

  // Issue is applied after retire so it wins on a collision; flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (addr_live(retire_en_i, retire_addr_i)) busy_d[retire_addr_i] = `False;
    if (addr_live(issue_en_i, issue_addr_i))   busy_d[issue_addr_i]  = `True;
    if (flush_i)                               busy_d = '0;
    busy_d[0] = `False;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign bypass1 = !rst_in && addr_live(retire_en_i, retire_addr_i) && (retire_addr_i == query_addr1_i);
  assign bypass2 = !rst_in && addr_live(retire_en_i, retire_addr_i) && (retire_addr_i == query_addr2_i);
`else
  assign bypass1 = `False;
  assign bypass2 = `False;
`endif

  assign busy1_o = addr_live(query_req1_i, query_addr1_i) && busy_q[query_addr1_i] && !bypass1;
  assign busy2_o = addr_live(query_req2_i, query_addr2_i) && busy_q[query_addr2_i] && !bypass2;

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module : regfile
// 31x32 register file with two combinational read ports and a busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by macro REGFILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile
  import regfile_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               write_en,
  input  logic [`RegAddrBus] write_addr,
  input  logic [`RegBus]     write_data,
  input  logic               read_request1,
  input  logic [`RegAddrBus] read_addr1,
  output logic [`RegBus]     read_data1,
  input  logic               read_request2,
  input  logic [`RegAddrBus] read_addr2,
  output logic [`RegBus]     read_data2,
  input  logic               issue_en,
  input  logic [`RegAddrBus] issue_addr,
  input  logic               flush,
  output logic               busy1,
  output logic               busy2
);

  word_t regs_q [REG_NUM-1:1];
  logic  write_live;
  logic  byp1;
  logic  byp2;

  assign write_live = addr_live(write_en, write_addr);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else if (rdy_in && write_live) begin
      regs_q[write_addr] <= write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = !rst_in && write_live && (write_addr == read_addr1);
  assign byp2 = !rst_in && write_live && (write_addr == read_addr2);
`else
  assign byp1 = `False;
  assign byp2 = `False;
`endif

  always_comb begin
    read_data1 = ZERO_WORD;
    if (addr_live(read_request1, read_addr1)) begin
      read_data1 = byp1 ? write_data : regs_q[read_addr1];
    end
  end

  always_comb begin
    read_data2 = ZERO_WORD;
    if (addr_live(read_request2, read_addr2)) begin
      read_data2 = byp2 ? write_data : regs_q[read_addr2];
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .issue_en_i    (issue_en),
    .issue_addr_i  (issue_addr),
    .retire_en_i   (write_en),
    .retire_addr_i (write_addr),
    .flush_i       (flush),
    .query_req1_i  (read_request1),
    .query_addr1_i (read_addr1),
    .query_req2_i  (read_request2),
    .query_addr2_i (read_addr2),
    .busy1_o       (busy1),
    .busy2_o       (busy2)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module : tb_regfile
// Self-checking bench: directed vector table, random traffic vs. array model, reset sequence.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        read_request1;
  logic [4:0]  read_addr1;
  logic [31:0] read_data1;
  logic        read_request2;
  logic [4:0]  read_addr2;
  logic [31:0] read_data2;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;
  logic        busy1;
  logic        busy2;

  int passed = 0;
  int total  = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];

  regfile dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_request1 (read_request1),
    .read_addr1    (read_addr1),
    .read_data1    (read_data1),
    .read_request2 (read_request2),
    .read_addr2    (read_addr2),
    .read_data2    (read_data2),
    .issue_en      (issue_en),
    .issue_addr    (issue_addr),
    .flush         (flush),
    .busy1         (busy1),
    .busy2         (busy2)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic ie; logic [4:0] ia; logic fl; logic rdy;
    logic r1; logic [4:0] a1; logic r2; logic [4:0] a2;
    logic [31:0] d1; logic b1; logic [31:0] d2; logic b2;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] ia, input logic fl, input logic rdy,
                              input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                              input logic [31:0] d1, input logic b1, input logic [31:0] d2, input logic b2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl; v.rdy = rdy;
    v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
    v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    write_en = v.we; write_addr = v.wa; write_data = v.wd;
    issue_en = v.ie; issue_addr = v.ia; flush = v.fl; rdy_in = v.rdy;
    read_request1 = v.r1; read_addr1 = v.a1;
    read_request2 = v.r2; read_addr2 = v.a2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'h0;
      mbusy[i] = 1'b0;
    end
  endtask

  // Advance one rising edge, applying the architectural update rules to the model.
  task automatic tick();
    @(posedge clk_in);
    if (!rst_in && rdy_in) begin
      if (write_en && write_addr != 0) begin
        mreg[write_addr]  = write_data;
        mbusy[write_addr] = 1'b0;
      end
      if (issue_en && issue_addr != 0) mbusy[issue_addr] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end
    #1;
  endtask

  function automatic logic byp_hit(input logic [4:0] a);
    return BYP && !rst_in && write_en && write_addr != 0 && write_addr == a;
  endfunction

  function automatic logic [31:0] exp_data(input logic req, input logic [4:0] a);
    if (!req || a == 0 || rst_in) return 32'h0;
    if (byp_hit(a)) return write_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic req, input logic [4:0] a);
    if (!req || a == 0 || rst_in) return 1'b0;
    if (byp_hit(a)) return 1'b0;
    return mbusy[a];
  endfunction

  vec_t tbl [13];
  vec_t idle;

  initial begin
    model_clear();
    idle = mk(0,0,0, 0,0,0,1, 0,0,0,0, 0,0,0,0);
    apply(idle);
    rst_in = 1'b1;
    read_request1 = 1'b1; read_addr1 = 5'd5;
    read_request2 = 1'b1; read_addr2 = 5'd5;
    @(negedge clk_in);
    @(negedge clk_in);
    check("reset d1", read_data1, 32'h0);
    check("reset b1", {31'h0, busy1}, 32'h0);
    check("reset d2", read_data2, 32'h0);
    check("reset b2", {31'h0, busy2}, 32'h0);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    //            we wa  wd            ie ia fl rdy r1 a1 r2 a2  d1                         b1        d2                         b2
    tbl[0]  = mk(0, 0,  32'h0,        0, 0, 0, 1,  1, 5, 1, 0,  32'h0,                     0,        32'h0,                     0);
    tbl[1]  = mk(1, 3,  32'hDEADBEEF, 0, 0, 0, 1,  1, 3, 1, 3,  BYP ? 32'hDEADBEEF : 32'h0, 0,        BYP ? 32'hDEADBEEF : 32'h0, 0);
    tbl[2]  = mk(1, 0,  32'h1234,     0, 0, 0, 1,  1, 3, 1, 3,  32'hDEADBEEF,              0,        32'hDEADBEEF,              0);
    tbl[3]  = mk(0, 0,  32'h0,        1, 7, 0, 1,  1, 0, 1, 0,  32'h0,                     0,        32'h0,                     0);
    tbl[4]  = mk(0, 0,  32'h0,        0, 0, 0, 1,  1, 7, 0, 7,  32'h0,                     1,        32'h0,                     0);
    tbl[5]  = mk(1, 7,  32'h55,       0, 0, 0, 1,  1, 7, 1, 7,  BYP ? 32'h55 : 32'h0,      !BYP,     BYP ? 32'h55 : 32'h0,      !BYP);
    tbl[6]  = mk(0, 0,  32'h0,        0, 0, 0, 1,  1, 7, 1, 7,  32'h55,                    0,        32'h55,                    0);
    tbl[7]  = mk(1, 9,  32'hA,        1, 9, 0, 1,  1, 9, 0, 9,  BYP ? 32'hA : 32'h0,       0,        32'h0,                     0);
    tbl[8]  = mk(0, 0,  32'h0,        0, 0, 0, 1,  1, 9, 1, 9,  32'hA,                     1,        32'hA,                     1);
    tbl[9]  = mk(0, 0,  32'h0,        1, 9, 1, 1,  1, 9, 1, 9,  32'hA,                     1,        32'hA,                     1);
    tbl[10] = mk(0, 0,  32'h0,        0, 0, 0, 1,  1, 9, 1, 9,  32'hA,                     0,        32'hA,                     0);
    tbl[11] = mk(1, 4,  32'h77,       1, 6, 0, 0,  1, 3, 0, 0,  32'hDEADBEEF,              0,        32'h0,                     0);
    tbl[12] = mk(0, 0,  32'h0,        0, 0, 0, 1,  1, 4, 1, 6,  32'h0,                     0,        32'h0,                     0);

    for (int r = 0; r < 13; r++) begin
      apply(tbl[r]);
      @(negedge clk_in);
      check($sformatf("vec%0d d1", r), read_data1, tbl[r].d1);
      check($sformatf("vec%0d b1", r), {31'h0, busy1}, {31'h0, tbl[r].b1});
      check($sformatf("vec%0d d2", r), read_data2, tbl[r].d2);
      check($sformatf("vec%0d b2", r), {31'h0, busy2}, {31'h0, tbl[r].b2});
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      write_en      = ($urandom_range(0, 2) != 0);
      write_addr    = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      write_data    = $urandom;
      issue_en      = ($urandom_range(0, 1) != 0);
      issue_addr    = 5'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 19) == 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      read_request1 = ($urandom_range(0, 3) != 0);
      read_addr1    = 5'($urandom_range(0, 7));
      read_request2 = ($urandom_range(0, 3) != 0);
      read_addr2    = ($urandom_range(0, 3) == 0) ? read_addr1 : 5'($urandom_range(0, 7));
      @(negedge clk_in);
      check($sformatf("rnd%0d d1", n), read_data1, exp_data(read_request1, read_addr1));
      check($sformatf("rnd%0d b1", n), {31'h0, busy1}, {31'h0, exp_busy(read_request1, read_addr1)});
      check($sformatf("rnd%0d d2", n), read_data2, exp_data(read_request2, read_addr2));
      check($sformatf("rnd%0d b2", n), {31'h0, busy2}, {31'h0, exp_busy(read_request2, read_addr2)});
      tick();
    end

    // Asynchronous reset between edges, then held across an edge with a pending write.
    apply(mk(1, 10, 32'h99, 1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    apply(mk(0, 0, 32'h0, 0, 0, 0, 1, 1, 10, 1, 11, 0, 0, 0, 0));
    @(negedge clk_in);
    check("pre-rst x10", read_data1, 32'h99);
    check("pre-rst busy x11", {31'h0, busy2}, 32'h1);
    #2;
    rst_in = 1'b1;
    model_clear();
    #1;
    check("async rst x10", read_data1, 32'h0);
    check("async rst busy x11", {31'h0, busy2}, 32'h0);
    apply(mk(1, 10, 32'h1234, 1, 11, 0, 1, 1, 10, 1, 11, 0, 0, 0, 0));
    @(posedge clk_in);
    #1;
    check("rst held x10", read_data1, 32'h0);
    check("rst held busy x11", {31'h0, busy2}, 32'h0);
    apply(mk(0, 0, 32'h0, 0, 0, 0, 1, 1, 10, 1, 11, 0, 0, 0, 0));
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("post-rst x10", read_data1, 32'h0);
    check("post-rst busy x11", {31'h0, busy2}, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
